// File: rtl/fpu_tag_rob.sv
// Tag allocator + reorder buffer: grants tags in order, absorbs out-of-order unit writebacks, retires in tag order.
// Latency: writeback -> out_valid_o is 1 cycle (no bypass); wb_err_o is a registered pulse 1 cycle after the bad write.
// Backpressure: out_ready_i low holds the head entry and out_* stable; alloc_ready_o drops when all DEPTH entries are in flight.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   flush_i                               synchronous discard of every entry (overrides alloc/wb/retire)
//   alloc_valid_i/alloc_ready_o/alloc_tag_o   tag request handshake; tag = tail pointer
//   wb_valid_i/wb_tag_i/wb_data_i/wb_status_i per-unit completion ports, port 0 has priority on a shared tag
//   wb_err_o                              pulse: a writeback was out of range, to an empty/done entry, or lost a collision
//   out_valid_o/out_ready_i/out_tag_o/out_data_o/out_status_o  in-order retire stream
//   occupancy_o                           entries currently allocated
// Optional: define RT_ROB_FLAGS_ACC_EN to add flags_clr_i / flags_o (sticky OR of retired status).
module fpu_tag_rob #(
  parameter int NUM_UNITS = 3,
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int STAT_W    = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  output logic [TAG_W-1:0]            alloc_tag_o,
  input  logic [NUM_UNITS-1:0]        wb_valid_i,
  input  logic [NUM_UNITS*TAG_W-1:0]  wb_tag_i,
  input  logic [NUM_UNITS*DATA_W-1:0] wb_data_i,
  input  logic [NUM_UNITS*STAT_W-1:0] wb_status_i,
  output logic                        wb_err_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [TAG_W-1:0]            out_tag_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [STAT_W-1:0]           out_status_o,
  output logic [$clog2(DEPTH):0]      occupancy_o
`ifdef RT_ROB_FLAGS_ACC_EN
  ,
  input  logic                        flags_clr_i,
  output logic [STAT_W-1:0]           flags_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W:0]   DEPTH_TAG = (TAG_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2) || (DEPTH > (1 << TAG_W))) begin : g_bad_cfg
    $error("fpu_tag_rob: DEPTH must be a power of two with 2 <= DEPTH <= 2**TAG_W");
  end

  typedef struct packed {
    logic [STAT_W-1:0] status;
    logic [DATA_W-1:0] data;
  } res_t;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] done_q;
  res_t             res_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic                 alloc_hs;
  logic                 retire_hs;
  logic [NUM_UNITS-1:0] wb_ok;
  logic [NUM_UNITS-1:0] wb_bad;
  logic [PTR_W-1:0]     wb_idx [NUM_UNITS];
  res_t                 wb_res [NUM_UNITS];

  // Ready comes from registered count only, so a retire from a full ROB
  // frees the slot for the next cycle, never the same one.
  assign alloc_ready_o = (cnt_q < DEPTH_CNT) && !flush_i;
  assign alloc_hs      = alloc_valid_i && alloc_ready_o;
  assign alloc_tag_o   = TAG_W'(tail_q);

  assign out_valid_o   = vld_q[head_q] && done_q[head_q] && !flush_i;
  assign retire_hs     = out_valid_o && out_ready_i;
  assign out_tag_o     = TAG_W'(head_q);
  assign out_data_o    = res_q[head_q].data;
  assign out_status_o  = res_q[head_q].status;
  assign occupancy_o   = cnt_q;
  assign wb_err_o      = err_q;

  // A write is legal when its tag is in range, the entry is waiting for a
  // result, and no lower-numbered port names the same tag this cycle.
  always_comb begin
    wb_ok  = '0;
    wb_bad = '0;
    for (int p = 0; p < NUM_UNITS; p++) begin
      wb_idx[p] = wb_tag_i[p*TAG_W +: PTR_W];
      wb_res[p] = {wb_status_i[p*STAT_W +: STAT_W], wb_data_i[p*DATA_W +: DATA_W]};
      if (wb_valid_i[p]) begin
        wb_ok[p] = ({1'b0, wb_tag_i[p*TAG_W +: TAG_W]} < DEPTH_TAG) &&
                   vld_q[wb_idx[p]] && !done_q[wb_idx[p]];
        for (int q = 0; q < p; q++) begin
          if (wb_valid_i[q] && (wb_tag_i[q*TAG_W +: TAG_W] == wb_tag_i[p*TAG_W +: TAG_W])) begin
            wb_ok[p] = 1'b0;
          end
        end
        wb_bad[p] = !wb_ok[p];
      end
    end
  end

  // Alloc (invalid tail entry), writeback (valid, not-done entry) and retire
  // (valid, done head entry) can never target the same entry in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
      end
    end else if (flush_i) begin
      vld_q  <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= |wb_bad;
      if (alloc_hs) begin
        vld_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + PTR_W'(1);
      end
      for (int p = 0; p < NUM_UNITS; p++) begin
        if (wb_ok[p]) begin
          done_q[wb_idx[p]] <= 1'b1;
          res_q[wb_idx[p]]  <= wb_res[p];
        end
      end
      if (retire_hs) begin
        vld_q[head_q]  <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(alloc_hs) - CNT_W'(retire_hs);
    end
  end

`ifdef RT_ROB_FLAGS_ACC_EN
  // Sticky exception flags; a clear coinciding with a retire keeps only the
  // retiring status so that result is not lost. Flush leaves it untouched.
  logic [STAT_W-1:0] flags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (flags_clr_i) begin
      flags_q <= retire_hs ? out_status_o : '0;
    end else if (retire_hs) begin
      flags_q <= flags_q | out_status_o;
    end
  end

  assign flags_o = flags_q;
`endif

endmodule
